// File: rtl/fib_bcd_display.sv
// Captures fibonacci results, converts them to BCD by shift-add-3 and
// drives a multiplexed 8-digit common-anode seven-segment display.
module fib_bcd_display #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        busy,
  output logic [19:0] bcd_out,
  output logic        bcd_valid,
  output logic [7:0]  an,
  output logic [7:0]  dec_cat
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   bin_q, bin_d;
  logic [19:0]   acc_q, acc_d;
  logic [3:0]    iter_q, iter_d;
  logic          pend_q, pend_d;
  logic [15:0]   pdata_q, pdata_d;
  logic          busy_q, busy_d;
  logic [19:0]   bcd_q, bcd_d;
  logic          bv_q, bv_d;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    an_q, an_d;
  logic [7:0]    cat_q, cat_d;

  logic [19:0]   adj;
  logic [19:0]   acc_n;
  logic [15:0]   bin_n;
  logic [3:0]    nib;
  logic          blank;

  always_comb begin
    adj = acc_q;
    for (int i = 0; i < 5; i++) begin
      if (adj[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    acc_n = {adj[18:0], bin_q[15]};
    bin_n = {bin_q[14:0], 1'b0};
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    acc_d   = acc_q;
    iter_d  = iter_q;
    pend_d  = pend_q;
    pdata_d = pdata_q;
    busy_d  = busy_q;
    bcd_d   = bcd_q;
    bv_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pend_q || in_valid) begin
          bin_d   = pend_q ? pdata_q : in_data;
          acc_d   = '0;
          iter_d  = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
          // a fresh sample alongside older pending data waits its turn
          pend_d  = pend_q && in_valid;
          if (pend_q && in_valid)
            pdata_d = in_data;
        end
      end
      SHIFT: begin
        acc_d  = acc_n;
        bin_d  = bin_n;
        iter_d = iter_q + 4'd1;
        if (iter_q == 4'd15)
          state_d = DONE;
        if (in_valid) begin
          pend_d  = 1'b1;
          pdata_d = in_data;
        end
      end
      DONE: begin
        bcd_d   = acc_q;
        bv_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
        if (in_valid) begin
          pend_d  = 1'b1;
          pdata_d = in_data;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      acc_q   <= '0;
      iter_q  <= '0;
      pend_q  <= 1'b0;
      pdata_q <= '0;
      busy_q  <= 1'b0;
      bcd_q   <= '0;
      bv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      acc_q   <= acc_d;
      iter_q  <= iter_d;
      pend_q  <= pend_d;
      pdata_q <= pdata_d;
      busy_q  <= busy_d;
      bcd_q   <= bcd_d;
      bv_q    <= bv_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else if (cnt_q == CW'(REFRESH_DIV - 1)) begin
      cnt_q <= '0;
      idx_q <= idx_q + 3'd1;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // digit k>=1 is blank when it and every higher digit are zero
  always_comb begin
    nib   = 4'h0;
    blank = 1'b1;
    case (idx_q)
      3'd0: begin nib = bcd_q[3:0];   blank = 1'b0;          end
      3'd1: begin nib = bcd_q[7:4];   blank = ~|bcd_q[19:4];  end
      3'd2: begin nib = bcd_q[11:8];  blank = ~|bcd_q[19:8];  end
      3'd3: begin nib = bcd_q[15:12]; blank = ~|bcd_q[19:12]; end
      3'd4: begin nib = bcd_q[19:16]; blank = ~|bcd_q[19:16]; end
      default: begin nib = 4'h0;      blank = 1'b1;           end
    endcase
  end

  always_comb begin
    cat_d = 8'hFF;
    unique case (nib)
      4'd0: cat_d = 8'hC0;
      4'd1: cat_d = 8'hF9;
      4'd2: cat_d = 8'hA4;
      4'd3: cat_d = 8'hB0;
      4'd4: cat_d = 8'h99;
      4'd5: cat_d = 8'h92;
      4'd6: cat_d = 8'h82;
      4'd7: cat_d = 8'hF8;
      4'd8: cat_d = 8'h80;
      4'd9: cat_d = 8'h90;
      default: cat_d = 8'hFF;
    endcase
    an_d = ~(8'h01 << idx_q);
    if (blank) begin
      cat_d = 8'hFF;
      an_d  = 8'hFF;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an_q  <= 8'hFF;
      cat_q <= 8'hFF;
    end else begin
      an_q  <= an_d;
      cat_q <= cat_d;
    end
  end

  assign busy      = busy_q;
  assign bcd_out   = bcd_q;
  assign bcd_valid = bv_q;
  assign an        = an_q;
  assign dec_cat   = cat_q;

endmodule

// File: tb/tb_fib_bcd_display.sv
// Scoreboard bench for fib_bcd_display: directed samples, queued
// expected BCD words, independent display sweep checks.
module tb_fib_bcd_display;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        busy;
  logic [19:0] bcd_out;
  logic        bcd_valid;
  logic [7:0]  an;
  logic [7:0]  dec_cat;

  typedef struct {
    logic [19:0] v;
    int          t;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  fib_bcd_display #(.REFRESH_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .busy     (busy),
    .bcd_out  (bcd_out),
    .bcd_valid(bcd_valid),
    .an       (an),
    .dec_cat  (dec_cat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mseg(input logic [3:0] n);
    logic [7:0] tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                             8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    if (n > 4'd9) return 8'hFF;
    return tbl[n];
  endfunction

  function automatic bit mblank(input int k, input logic [19:0] b);
    logic [19:0] hi;
    if (k == 0) return 1'b0;
    if (k >= 5) return 1'b1;
    hi = b >> (4 * k);
    return hi == 20'h0;
  endfunction

  // monitor: every pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst && bcd_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", int'(bcd_out), -1);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("bcd_out", int'(bcd_out), int'(e.v));
        chk("busy_at_pulse", int'(busy), 0);
        if (e.t >= 0) chk("latency", cyc, e.t);
      end
    end
  end

  task automatic send(input logic [15:0] v, input logic [19:0] ev,
                      input bit push);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = v;
    if (push) begin
      e.v = ev;
      e.t = cyc + 18;
      q.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
  endtask

  task automatic disp(input logic [19:0] b);
    int seen [8];
    int k;
    foreach (seen[i]) seen[i] = 0;
    for (int s = 0; s < 40; s++) begin
      @(negedge clk);
      if (an == 8'hFF) begin
        chk("blank_cat", int'(dec_cat), 8'hFF);
      end else begin
        k = -1;
        for (int j = 0; j < 8; j++)
          if (an == ~(8'h01 << j)) k = j;
        if (k < 0) begin
          chk("an_onehot", int'(an), -1);
        end else begin
          seen[k]++;
          chk("digit_lit_ok", int'(mblank(k, b)), 0);
          chk("seg", int'(dec_cat), int'(mseg(b[4*k +: 4])));
        end
      end
    end
    for (int j = 0; j < 8; j++)
      chk("digit_shown", int'(seen[j] > 0), int'(!mblank(j, b)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fib [18] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144,
                     233, 377, 610, 987, 1597, 2584};
    int c;
    int nb;
    exp_t e;
    rst = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_bv", int'(bcd_valid), 0);
    chk("rst_bcd", int'(bcd_out), 0);
    chk("rst_an", int'(an), 8'hFF);
    chk("rst_cat", int'(dec_cat), 8'hFF);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 55: latency and busy width
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 16'd55;
    e.v = 20'h00055;
    e.t = cyc + 18;
    q.push_back(e);
    nb = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (busy) nb++;
    end
    chk("busy_cycles", nb, 17);
    drain();
    disp(20'h00055);

    send(16'd65535, 20'h65535, 1'b1);
    drain();
    disp(20'h65535);

    // back-to-back samples: first captured, newest pending kept
    @(negedge clk);
    c = cyc;
    e.v = 20'h00001;
    e.t = c + 18;
    q.push_back(e);
    e.v = 20'h02584;
    e.t = c + 36;
    q.push_back(e);
    for (int i = 0; i < 18; i++) begin
      in_valid = 1'b1;
      in_data = 16'(fib[i]);
      @(negedge clk);
    end
    in_valid = 1'b0;
    drain();
    repeat (30) @(negedge clk);

    send(16'd0, 20'h00000, 1'b1);
    drain();
    disp(20'h00000);

    send(16'd46368, 20'h46368, 1'b1);
    drain();

    // reset in the middle of a conversion with data pending
    @(negedge clk);
    c = cyc;
    in_valid = 1'b1;
    in_data = 16'd1234;
    @(negedge clk);
    in_data = 16'd777;
    @(negedge clk);
    in_valid = 1'b0;
    while (cyc < c + 9) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rst_an", int'(an), 8'hFF);
    chk("mid_rst_cat", int'(dec_cat), 8'hFF);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_bv", int'(bcd_valid), 0);
    chk("mid_rst_bcd", int'(bcd_out), 0);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    send(16'd1000, 20'h01000, 1'b1);
    drain();
    disp(20'h01000);

    repeat (30) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
